// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-back data cache; define DCACHE_STATS_EN for hit/miss counters
module dcache_dm #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINES      = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_read,
  input  logic                    req_write,
  input  logic                    req_byte,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [31:0]             req_wdata,
  output logic [31:0]             rdata,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [32*LINE_WORDS-1:0] mem_wdata,
  input  logic [32*LINE_WORDS-1:0] mem_rdata,
  input  logic                    mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LINE_W = 32 * LINE_WORDS;
  // With a single-word line the select bit is forced to zero by the mask
  localparam logic [WSEL_W-1:0] WSEL_MASK = WSEL_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL} state_t;

  state_t r_state, w_state_nxt;

  logic [LINE_W-1:0]     r_data [LINES];
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [LINES-1:0]      r_valid;
  logic [LINES-1:0]      r_dirty;
  logic [IDX_W-1:0]      r_miss_index;
  logic [TAG_W-1:0]      r_miss_tag;

  logic                  r_mem_req, w_mem_req_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [LINE_W-1:0]     r_mem_wdata, w_mem_wdata_nxt;

  logic [IDX_W-1:0]      w_index;
  logic [TAG_W-1:0]      w_tag;
  logic [WSEL_W-1:0]     w_word;
  logic [LINE_W-1:0]     w_line;
  logic [LINE_W-1:0]     w_line_upd;
  logic [31:0]           w_word_data;
  logic                  w_active;
  logic                  w_hit;
  logic                  w_idle;
  logic                  w_miss_start;
  logic                  w_hit_done;

  assign w_index      = req_addr[OFF_W +: IDX_W];
  assign w_tag        = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_word       = req_addr[2 +: WSEL_W] & WSEL_MASK;
  assign w_line       = r_data[w_index];
  assign w_active     = req_read | req_write;
  assign w_hit        = w_active && r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_idle       = (r_state == S_IDLE);
  assign w_miss_start = w_idle && w_active && !w_hit;
  // Only IDLE completes requests; a hit seen while the FSM is busy is retried later
  assign w_hit_done   = w_idle && w_hit;

  assign stall     = (w_active && !w_hit) || !w_idle;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Select the addressed word and build the store-merged copy of the line
  always_comb begin
    w_word_data = '0;
    w_line_upd  = w_line;
    for (int w = 0; w < LINE_WORDS; w++) begin
      if (w_word == WSEL_W'(w)) begin
        w_word_data = w_line[w*32 +: 32];
      end
      for (int b = 0; b < 4; b++) begin
        if ((w_word == WSEL_W'(w)) && (!req_byte || (req_addr[1:0] == 2'(b)))) begin
          w_line_upd[w*32 + b*8 +: 8] = req_byte ? req_wdata[7:0] : req_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Load data: full word, or the little-endian byte lane zero-extended
  always_comb begin
    rdata = w_word_data;
    if (req_byte) begin
      case (req_addr[1:0])
        2'd0:    rdata = {24'b0, w_word_data[7:0]};
        2'd1:    rdata = {24'b0, w_word_data[15:8]};
        2'd2:    rdata = {24'b0, w_word_data[23:16]};
        default: rdata = {24'b0, w_word_data[31:24]};
      endcase
    end
  end

  // Miss FSM next state and next values of the registered memory-port outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_active && !w_hit) begin
          w_mem_req_nxt = 1'b1;
          if (r_valid[w_index] && r_dirty[w_index]) begin
            w_state_nxt     = S_WRITEBACK;
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = {r_tag[w_index], w_index, {OFF_W{1'b0}}};
            w_mem_wdata_nxt = w_line;
          end else begin
            w_state_nxt    = S_REFILL;
            w_mem_we_nxt   = 1'b0;
            w_mem_addr_nxt = {w_tag, w_index, {OFF_W{1'b0}}};
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_ack) begin
          // mem_req stays high: the refill follows back-to-back
          w_state_nxt    = S_REFILL;
          w_mem_we_nxt   = 1'b0;
          w_mem_addr_nxt = {r_miss_tag, r_miss_index, {OFF_W{1'b0}}};
        end
      end
      S_REFILL: begin
        if (mem_ack) begin
          w_state_nxt   = S_IDLE;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, memory-port registers and the latched miss line address
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_miss_index <= '0;
      r_miss_tag   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      // The fill target is captured so a dropped request cannot redirect it
      if (w_miss_start) begin
        r_miss_index <= w_index;
        r_miss_tag   <= w_tag;
      end
    end
  end

  // Line arrays: store hits, dirty clear after write-back, install on refill
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (w_hit_done && req_write) begin
        r_data[w_index]  <= w_line_upd;
        r_dirty[w_index] <= 1'b1;
      end
      if ((r_state == S_WRITEBACK) && mem_ack) begin
        r_dirty[r_miss_index] <= 1'b0;
      end
      if ((r_state == S_REFILL) && mem_ack) begin
        r_data[r_miss_index]  <= mem_rdata;
        r_tag[r_miss_index]   <= r_miss_tag;
        r_valid[r_miss_index] <= 1'b1;
        r_dirty[r_miss_index] <= 1'b0;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

  // Completed hits (including post-refill replays) and miss-handling entries
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_done) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss_start) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end
`endif

endmodule
